// File: rtl/snoop_mem_responder.sv
// rtl/snoop_mem_responder.sv - snoop-side downstream memory responder model
//
// Purpose: accepts one cache downstream request at a time (RD/RFO/INV/WB),
// waits MEM_LAT cycles, then presents a registered response computed from a
// small backing store and a peer-presence bit vector. A modelled peer cache
// can mark lines as present through the peer_set port at any time.
//
// Ports:
//   clk, rst            - rising-edge clock, asynchronous active-high reset
//   sdreq_valid/ready   - request handshake (ready only while idle)
//   sdreq_op/addr/data  - request opcode, line address, writeback data
//   sursp_valid/ready   - response handshake
//   sursp_rsp/data      - response code and returned line data
//   peer_set_valid/addr - peer acquires the line at peer_set_addr
module snoop_mem_responder #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int IDX_WIDTH  = 4,
  parameter int MEM_LAT    = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  sdreq_valid,
  output logic                  sdreq_ready,
  input  logic [2:0]            sdreq_op,
  input  logic [ADDR_WIDTH-1:0] sdreq_addr,
  input  logic [DATA_WIDTH-1:0] sdreq_data,
  output logic                  sursp_valid,
  input  logic                  sursp_ready,
  output logic [2:0]            sursp_rsp,
  output logic [DATA_WIDTH-1:0] sursp_data,
  input  logic                  peer_set_valid,
  input  logic [ADDR_WIDTH-1:0] peer_set_addr
);

  localparam int DEPTH = 1 << IDX_WIDTH;

  localparam logic [2:0] SDREQ_RD  = 3'd0;
  localparam logic [2:0] SDREQ_RFO = 3'd1;
  localparam logic [2:0] SDREQ_INV = 3'd2;
  localparam logic [2:0] SDREQ_WB  = 3'd3;

  localparam logic [2:0] SURSP_OKAY  = 3'd0;
  localparam logic [2:0] SURSP_FETCH = 3'd1;
  localparam logic [2:0] SURSP_SNOOP = 3'd2;
  localparam logic [2:0] SURSP_ERROR = 3'd3;

  localparam logic [3:0] LAT_LOAD = 4'(MEM_LAT - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t                 state_q, state_d;
  logic [3:0]             cnt_q, cnt_d;
  logic [2:0]             op_q;
  logic [IDX_WIDTH-1:0]   idx_q;
  logic [DATA_WIDTH-1:0]  wdata_q;
  logic [2:0]             rsp_q, rsp_d;
  logic [DATA_WIDTH-1:0]  rdata_q, rdata_d;
  logic [DATA_WIDTH-1:0]  mem_q [DEPTH];
  logic [DEPTH-1:0]       peer_q;

  logic                   req_hs;
  logic                   complete;
  logic                   peer_clr;
  logic                   mem_wr;
  logic [IDX_WIDTH-1:0]   peer_idx;
  logic                   unused_addr_bits;

  // Upper address bits alias onto the same line by design.
  assign peer_idx         = peer_set_addr[IDX_WIDTH-1:0];
  assign unused_addr_bits = ^{sdreq_addr[ADDR_WIDTH-1:IDX_WIDTH],
                              peer_set_addr[ADDR_WIDTH-1:IDX_WIDTH]};

  // Ready is gated by rst so it stays low for the whole reset pulse.
  assign sdreq_ready = (state_q == S_IDLE) && !rst;
  assign req_hs      = sdreq_valid && sdreq_ready;
  assign sursp_valid = (state_q == S_RESP);
  assign sursp_rsp   = rsp_q;
  assign sursp_data  = rdata_q;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    complete = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req_hs) begin
          state_d = S_WAIT;
          cnt_d   = LAT_LOAD;
        end
      end
      S_WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d  = S_RESP;
          complete = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_RESP: begin
        if (sursp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Lookup against current (pre-update) store contents.
  always_comb begin
    rsp_d    = SURSP_ERROR;
    rdata_d  = '0;
    peer_clr = 1'b0;
    mem_wr   = 1'b0;
    case (op_q)
      SDREQ_RD: begin
        rsp_d   = peer_q[idx_q] ? SURSP_SNOOP : SURSP_FETCH;
        rdata_d = mem_q[idx_q];
      end
      SDREQ_RFO: begin
        rsp_d    = peer_q[idx_q] ? SURSP_SNOOP : SURSP_FETCH;
        rdata_d  = mem_q[idx_q];
        peer_clr = 1'b1;
      end
      SDREQ_INV: begin
        rsp_d    = SURSP_OKAY;
        peer_clr = 1'b1;
      end
      SDREQ_WB: begin
        rsp_d  = SURSP_OKAY;
        mem_wr = 1'b1;
      end
      default: rsp_d = SURSP_ERROR;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      idx_q   <= '0;
      wdata_q <= '0;
      rsp_q   <= '0;
      rdata_q <= '0;
      peer_q  <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (req_hs) begin
        op_q    <= sdreq_op;
        idx_q   <= sdreq_addr[IDX_WIDTH-1:0];
        wdata_q <= sdreq_data;
      end
      if (complete) begin
        rsp_q   <= rsp_d;
        rdata_q <= rdata_d;
        if (mem_wr)   mem_q[idx_q]  <= wdata_q;
        if (peer_clr) peer_q[idx_q] <= 1'b0;
      end
      // Placed after the clear so a same-edge peer acquisition wins.
      if (peer_set_valid) peer_q[peer_idx] <= 1'b1;
    end
  end

endmodule

// File: tb/tb_snoop_mem_responder.sv
// tb/tb_snoop_mem_responder.sv - directed self-checking bench for snoop_mem_responder
module tb_snoop_mem_responder;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int LAT = 4;

  localparam logic [2:0] RD = 3'd0, RFO = 3'd1, INV = 3'd2, WB = 3'd3;
  localparam logic [2:0] OKAY = 3'd0, FETCH = 3'd1, SNOOP = 3'd2, ERROR = 3'd3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          sdreq_valid = 1'b0;
  logic          sdreq_ready;
  logic [2:0]    sdreq_op = '0;
  logic [AW-1:0] sdreq_addr = '0;
  logic [DW-1:0] sdreq_data = '0;
  logic          sursp_valid;
  logic          sursp_ready = 1'b0;
  logic [2:0]    sursp_rsp;
  logic [DW-1:0] sursp_data;
  logic          peer_set_valid = 1'b0;
  logic [AW-1:0] peer_set_addr = '0;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  snoop_mem_responder #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .IDX_WIDTH(4), .MEM_LAT(LAT)
  ) dut (
    .clk(clk), .rst(rst),
    .sdreq_valid(sdreq_valid), .sdreq_ready(sdreq_ready),
    .sdreq_op(sdreq_op), .sdreq_addr(sdreq_addr), .sdreq_data(sdreq_data),
    .sursp_valid(sursp_valid), .sursp_ready(sursp_ready),
    .sursp_rsp(sursp_rsp), .sursp_data(sursp_data),
    .peer_set_valid(peer_set_valid), .peer_set_addr(peer_set_addr)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue one request and collect its response. When pset is set, a peer
  // acquisition of pset_addr is driven on the completing edge. hold is the
  // number of cycles sursp_ready is kept low after valid rises.
  task automatic req(input logic [2:0] op, input logic [AW-1:0] addr,
                     input logic [DW-1:0] data, input bit pset,
                     input logic [AW-1:0] pset_addr, input int hold,
                     output logic [2:0] rsp, output logic [DW-1:0] rdata,
                     output int lat);
    int n;
    sdreq_valid = 1'b1;
    sdreq_op    = op;
    sdreq_addr  = addr;
    sdreq_data  = data;
    n = 0;
    while (!sdreq_ready && n < 50) begin step(); n++; end
    if (n >= 50) chk("accept_timeout", 64'(n), 64'd0);
    step();
    sdreq_valid = 1'b0;
    lat = 0;
    while (!sursp_valid && lat < 50) begin
      if (pset && lat == LAT - 1) begin
        peer_set_valid = 1'b1;
        peer_set_addr  = pset_addr;
      end
      step();
      peer_set_valid = 1'b0;
      lat++;
    end
    if (lat >= 50) chk("resp_timeout", 64'(lat), 64'd0);
    rsp   = sursp_rsp;
    rdata = sursp_data;
    for (int i = 0; i < hold; i++) begin
      step();
      chk("hold_valid", 64'(sursp_valid), 64'd1);
      chk("hold_rsp", 64'(sursp_rsp), 64'(rsp));
      chk("hold_data", 64'(sursp_data), 64'(rdata));
      chk("hold_sdreq_ready", 64'(sdreq_ready), 64'd0);
    end
    sursp_ready = 1'b1;
    #3;
    chk("ready_low_in_resp", 64'(sdreq_ready), 64'd0);
    step();
    sursp_ready = 1'b0;
    chk("ready_after_rsp_hs", 64'(sdreq_ready), 64'd1);
  endtask

  logic [2:0]    r;
  logic [DW-1:0] d;
  int            l;

  initial begin
    #2;
    chk("rst_sdreq_ready", 64'(sdreq_ready), 64'd0);
    chk("rst_sursp_valid", 64'(sursp_valid), 64'd0);
    chk("rst_sursp_rsp", 64'(sursp_rsp), 64'd0);
    chk("rst_sursp_data", 64'(sursp_data), 64'd0);
    step(); step();
    rst = 1'b0;
    #1;
    chk("post_rst_ready", 64'(sdreq_ready), 64'd1);
    step();

    // Read of an untouched line: miss, zero data, MEM_LAT latency.
    req(RD, 32'h3, '0, 0, '0, 0, r, d, l);
    chk("rd3_lat", 64'(l), 64'(LAT));
    chk("rd3_rsp", 64'(r), 64'(FETCH));
    chk("rd3_data", 64'(d), 64'd0);

    // Writeback then read through an aliased address.
    req(WB, 32'h5, 32'hDEADBEEF, 0, '0, 0, r, d, l);
    chk("wb5_rsp", 64'(r), 64'(OKAY));
    chk("wb5_data", 64'(d), 64'd0);
    req(RD, 32'h15, '0, 0, '0, 0, r, d, l);
    chk("rd15_rsp", 64'(r), 64'(FETCH));
    chk("rd15_data", 64'(d), 64'hDEADBEEF);

    // Peer acquisition seen by RFO, which then clears it.
    peer_set_valid = 1'b1;
    peer_set_addr  = 32'h7;
    step();
    peer_set_valid = 1'b0;
    req(RFO, 32'h7, '0, 0, '0, 0, r, d, l);
    chk("rfo7_rsp", 64'(r), 64'(SNOOP));
    chk("rfo7_data", 64'(d), 64'd0);
    req(RD, 32'h7, '0, 0, '0, 0, r, d, l);
    chk("rd7_rsp", 64'(r), 64'(FETCH));

    // Peer set on the RFO completion edge: set wins, response pre-edge.
    req(RFO, 32'h2, '0, 1, 32'hF2, 0, r, d, l);
    chk("rfo2_rsp", 64'(r), 64'(FETCH));
    req(RD, 32'h2, '0, 0, '0, 0, r, d, l);
    chk("rd2_rsp", 64'(r), 64'(SNOOP));

    // Invalidate clears the peer bit.
    req(INV, 32'h2, '0, 0, '0, 0, r, d, l);
    chk("inv2_rsp", 64'(r), 64'(OKAY));
    req(RD, 32'h2, '0, 0, '0, 0, r, d, l);
    chk("rd2b_rsp", 64'(r), 64'(FETCH));

    // Illegal op, response held under backpressure, no store change.
    req(3'b110, 32'h5, 32'h1234, 0, '0, 5, r, d, l);
    chk("err_rsp", 64'(r), 64'(ERROR));
    chk("err_data", 64'(d), 64'd0);
    req(RD, 32'h5, '0, 0, '0, 0, r, d, l);
    chk("rd5_after_err", 64'(d), 64'hDEADBEEF);

    // Reset during WAIT of a writeback drops it.
    sdreq_valid = 1'b1;
    sdreq_op    = WB;
    sdreq_addr  = 32'h1;
    sdreq_data  = 32'h55;
    step();
    sdreq_valid = 1'b0;
    step();
    rst = 1'b1;
    #1;
    chk("midrst_ready", 64'(sdreq_ready), 64'd0);
    chk("midrst_valid", 64'(sursp_valid), 64'd0);
    step();
    rst = 1'b0;
    #1;
    chk("midrst_post_ready", 64'(sdreq_ready), 64'd1);
    for (int i = 0; i < LAT + 2; i++) begin
      step();
      chk("midrst_no_resp", 64'(sursp_valid), 64'd0);
    end
    req(RD, 32'h1, '0, 0, '0, 0, r, d, l);
    chk("rd1_rsp", 64'(r), 64'(FETCH));
    chk("rd1_data", 64'(d), 64'd0);
    // Reset also cleared the earlier writeback.
    req(RD, 32'h5, '0, 0, '0, 0, r, d, l);
    chk("rd5_after_rst", 64'(d), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got timeout expected finish");
    $fatal(1);
  end

endmodule
